// File: rtl/inst_buffer_mw.sv
// Multi-wide instruction buffer: accepts up to four fetched lanes per cycle and
// presents up to DEQ_WIDTH instructions per cycle, in order, from a circular array.
module inst_buffer_mw #(
  parameter int DEPTH     = 16,
  parameter int DEQ_WIDTH = 2
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       redirect_valid,
  input  logic                       fetch_valid,
  output logic                       fetch_ready,
  input  logic [127:0]               fetch_insts,
  input  logic [63:0]                fetch_pc,
  input  logic [3:0]                 fetch_mask,
  input  logic                       fetch_predicttaken,
  input  logic [1:0]                 fetch_predictlane,
  input  logic [31:0]                fetch_predicttarget,
  output logic [DEQ_WIDTH-1:0]       out_valid,
  input  logic                       out_ready,
  output logic [32*DEQ_WIDTH-1:0]    out_inst,
  output logic [64*DEQ_WIDTH-1:0]    out_pc,
  output logic [DEQ_WIDTH-1:0]       out_predicttaken,
  output logic [32*DEQ_WIDTH-1:0]    out_predicttarget,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
    logic        taken;
    logic [31:0] target;
  } entry_t;

  entry_t mem [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW-1:0] count_q, count_d;

  logic [PW-1:0] free_slots;
  logic          enq_fire;
  logic          deq_fire;
  logic [2:0]    enq_n;
  logic [PW-1:0] deq_n;
  logic [3:0]    lane_we;
  logic [AW-1:0] lane_addr [4];
  entry_t        lane_entry [4];
  entry_t        rd_entry [DEQ_WIDTH];

  // Readiness is judged on the registered occupancy only, so a block is never
  // accepted on the strength of a dequeue happening in the same cycle.
  assign free_slots  = PW'(DEPTH) - count_q;
  assign fetch_ready = (free_slots >= PW'(4)) & ~redirect_valid;
  assign enq_fire    = fetch_valid & fetch_ready;
  assign deq_fire    = out_ready & out_valid[0];
  assign deq_n       = (count_q < PW'(DEQ_WIDTH)) ? count_q : PW'(DEQ_WIDTH);
  assign count       = count_q;

  // Each valid lane lands at tail plus the number of valid lanes below it.
  always_comb begin
    enq_n   = '0;
    lane_we = '0;
    for (int i = 0; i < 4; i++) begin
      lane_addr[i]         = tail_q[AW-1:0] + AW'(enq_n);
      lane_entry[i].inst   = fetch_insts[32*i +: 32];
      lane_entry[i].pc     = fetch_pc + 64'(4 * i);
      lane_entry[i].taken  = fetch_predicttaken & (fetch_predictlane == 2'(i)) & fetch_mask[i];
      lane_entry[i].target = lane_entry[i].taken ? fetch_predicttarget : '0;
      lane_we[i]           = enq_fire & fetch_mask[i];
      enq_n                = enq_n + {2'b00, fetch_mask[i]};
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (lane_we[i]) mem[lane_addr[i]] <= lane_entry[i];
    end
  end

  always_comb begin
    out_valid         = '0;
    out_inst          = '0;
    out_pc            = '0;
    out_predicttaken  = '0;
    out_predicttarget = '0;
    for (int k = 0; k < DEQ_WIDTH; k++) begin
      rd_entry[k] = mem[head_q[AW-1:0] + AW'(k)];
      if (count_q > PW'(k)) begin
        out_valid[k]                = 1'b1;
        out_inst[32*k +: 32]        = rd_entry[k].inst;
        out_pc[64*k +: 64]          = rd_entry[k].pc;
        out_predicttaken[k]         = rd_entry[k].taken;
        out_predicttarget[32*k +: 32] = rd_entry[k].target;
      end
    end
  end

  // A redirect wins over everything else that cycle and empties the buffer.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (redirect_valid) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq_fire) tail_d = tail_q + PW'(enq_n);
      if (deq_fire) head_d = head_q + deq_n;
      count_d = count_q + (enq_fire ? PW'(enq_n) : '0) - (deq_fire ? deq_n : '0);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_inst_buffer_mw.sv
// Self-checking bench for inst_buffer_mw: directed vector table, corner-case
// sequences and randomized traffic against a queue-based reference model.
module tb_inst_buffer_mw;

  localparam int DEPTH = 16;
  localparam int DW    = 2;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          redirect_valid;
  logic          fetch_valid;
  logic          fetch_ready;
  logic [127:0]  fetch_insts;
  logic [63:0]   fetch_pc;
  logic [3:0]    fetch_mask;
  logic          fetch_predicttaken;
  logic [1:0]    fetch_predictlane;
  logic [31:0]   fetch_predicttarget;
  logic [DW-1:0] out_valid;
  logic          out_ready;
  logic [32*DW-1:0] out_inst;
  logic [64*DW-1:0] out_pc;
  logic [DW-1:0] out_predicttaken;
  logic [32*DW-1:0] out_predicttarget;
  logic [4:0]    count;

  inst_buffer_mw #(.DEPTH(DEPTH), .DEQ_WIDTH(DW)) dut (
    .clock(clock), .reset_n(reset_n), .redirect_valid(redirect_valid),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_insts(fetch_insts),
    .fetch_pc(fetch_pc), .fetch_mask(fetch_mask), .fetch_predicttaken(fetch_predicttaken),
    .fetch_predictlane(fetch_predictlane), .fetch_predicttarget(fetch_predicttarget),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .out_predicttaken(out_predicttaken), .out_predicttarget(out_predicttarget), .count(count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
    logic        taken;
    logic [31:0] tgt;
  } ent_t;

  typedef struct {
    logic         fv;
    logic [127:0] insts;
    logic [63:0]  pc;
    logic [3:0]   mask;
    logic         pt;
    logic [1:0]   pl;
    logic [31:0]  ptgt;
    logic         ordy;
    int           ecount;
    logic [1:0]   evalid;
    logic [31:0]  einst0, einst1;
    logic [63:0]  epc0, epc1;
    logic         et0, et1;
    logic [31:0]  etg0, etg1;
  } vec_t;

  ent_t model_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic rd, input logic fv, input logic [127:0] insts,
                               input logic [63:0] pc, input logic [3:0] mask, input logic pt,
                               input logic [1:0] pl, input logic [31:0] ptgt, input logic ordy);
    redirect_valid      = rd;
    fetch_valid         = fv;
    fetch_insts         = insts;
    fetch_pc            = pc;
    fetch_mask          = mask;
    fetch_predicttaken  = pt;
    fetch_predictlane   = pl;
    fetch_predicttarget = ptgt;
    out_ready           = ordy;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, '0, '0, 4'b0, 1'b0, 2'd0, '0, 1'b0);
  endtask

  // Compare every visible output against the front of the reference queue.
  task automatic checkOutput(input string tag);
    ent_t e;
    check($sformatf("%s count", tag), count, model_q.size());
    for (int k = 0; k < DW; k++) begin
      if (k < model_q.size()) e = model_q[k];
      else e = '{inst: '0, pc: '0, taken: 1'b0, tgt: '0};
      check($sformatf("%s valid%0d", tag, k), out_valid[k], (k < model_q.size()));
      check($sformatf("%s inst%0d", tag, k), out_inst[32*k +: 32], e.inst);
      check($sformatf("%s pc%0d", tag, k), out_pc[64*k +: 64], e.pc);
      check($sformatf("%s taken%0d", tag, k), out_predicttaken[k], e.taken);
      check($sformatf("%s tgt%0d", tag, k), out_predicttarget[32*k +: 32], e.tgt);
    end
  endtask

  // One clock with the currently driven inputs, advancing the reference model.
  task automatic cycleModel(input string tag);
    bit   rdy;
    int   n;
    ent_t e;
    rdy = ((DEPTH - model_q.size()) >= 4) && !redirect_valid;
    #1 check($sformatf("%s fetch_ready", tag), fetch_ready, rdy);
    @(posedge clock);
    if (redirect_valid) begin
      model_q.delete();
    end else begin
      if (out_ready && model_q.size() > 0) begin
        n = (model_q.size() < DW) ? model_q.size() : DW;
        for (int j = 0; j < n; j++) void'(model_q.pop_front());
      end
      if (fetch_valid && rdy) begin
        for (int i = 0; i < 4; i++) begin
          if (fetch_mask[i]) begin
            e.inst  = fetch_insts[32*i +: 32];
            e.pc    = fetch_pc + 64'(4 * i);
            e.taken = fetch_predicttaken && (fetch_predictlane == 2'(i));
            e.tgt   = e.taken ? fetch_predicttarget : 32'h0;
            model_q.push_back(e);
          end
        end
      end
    end
    #1;
    checkOutput(tag);
  endtask

  vec_t tbl [9];
  logic [31:0] seq_inst;
  logic [3:0]  rmask;
  int          rs, rl;

  initial begin
    tbl[0] = '{1, {32'h44, 32'h33, 32'h22, 32'h11}, 64'h8000_0000, 4'b1111, 0, 0, 0, 0,
               4, 2'b11, 32'h11, 32'h22, 64'h8000_0000, 64'h8000_0004, 0, 0, 0, 0};
    tbl[1] = '{0, '0, '0, 0, 0, 0, 0, 1,
               2, 2'b11, 32'h33, 32'h44, 64'h8000_0008, 64'h8000_000C, 0, 0, 0, 0};
    tbl[2] = '{0, '0, '0, 0, 0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[3] = '{1, {32'hDD, 32'hCC, 32'hBB, 32'hAA}, 64'h8000_0000, 4'b0110, 1, 2, 32'h8000_0100, 0,
               2, 2'b11, 32'hBB, 32'hCC, 64'h8000_0004, 64'h8000_0008, 0, 1, 0, 32'h8000_0100};
    tbl[4] = '{0, '0, '0, 0, 0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[5] = '{1, {96'h0, 32'h55}, 64'h1000, 4'b0001, 1, 1, 32'hDEAD_BEEF, 0,
               1, 2'b01, 32'h55, 0, 64'h1000, 0, 0, 0, 0, 0};
    tbl[6] = '{0, '0, '0, 0, 0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[7] = '{1, {64'h0, 32'h77, 32'h66}, 64'hFFFF_FFFF_FFFF_FFFC, 4'b0011, 1, 0, 32'h1234_5678, 0,
               2, 2'b11, 32'h66, 32'h77, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 1, 0, 32'h1234_5678, 0};
    tbl[8] = '{0, '0, '0, 0, 0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0};

    reset_n = 1'b0;
    idle();
    #12;
    check("reset count", count, 0);
    check("reset out_valid", out_valid, 0);
    check("reset out_predicttaken", out_predicttaken, 0);
    check("reset out_inst", out_inst, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check("post-reset fetch_ready", fetch_ready, 1);

    for (int v = 0; v < 9; v++) begin
      applyStimulus(1'b0, tbl[v].fv, tbl[v].insts, tbl[v].pc, tbl[v].mask, tbl[v].pt,
                    tbl[v].pl, tbl[v].ptgt, tbl[v].ordy);
      @(posedge clock);
      #1;
      idle();
      check($sformatf("vec%0d count", v), count, tbl[v].ecount);
      check($sformatf("vec%0d valid", v), out_valid, tbl[v].evalid);
      check($sformatf("vec%0d inst0", v), out_inst[31:0], tbl[v].einst0);
      check($sformatf("vec%0d inst1", v), out_inst[63:32], tbl[v].einst1);
      check($sformatf("vec%0d pc0", v), out_pc[63:0], tbl[v].epc0);
      check($sformatf("vec%0d pc1", v), out_pc[127:64], tbl[v].epc1);
      check($sformatf("vec%0d taken", v), out_predicttaken, {tbl[v].et1, tbl[v].et0});
      check($sformatf("vec%0d tgt0", v), out_predicttarget[31:0], tbl[v].etg0);
      check($sformatf("vec%0d tgt1", v), out_predicttarget[63:32], tbl[v].etg1);
    end

    // Fill to 13 entries, probe the readiness threshold, then drain two.
    for (int b = 0; b < 3; b++) begin
      applyStimulus(1'b0, 1'b1, {32'h100 + 32'(4*b+3), 32'h100 + 32'(4*b+2), 32'h100 + 32'(4*b+1), 32'h100 + 32'(4*b)},
                    64'h2000 + 64'(16*b), 4'b1111, 1'b0, 2'd0, '0, 1'b0);
      cycleModel($sformatf("fill%0d", b));
    end
    idle();
    #1 check("count12 fetch_ready", fetch_ready, 1);
    applyStimulus(1'b0, 1'b1, {96'h0, 32'h10C}, 64'h2030, 4'b0001, 1'b0, 2'd0, '0, 1'b0);
    cycleModel("fill13");
    check("count13 fetch_ready", fetch_ready, 0);
    applyStimulus(1'b0, 1'b1, {4{32'hBAD}}, 64'h9000, 4'b1111, 1'b0, 2'd0, '0, 1'b0);
    cycleModel("blocked");
    check("blocked count", count, 13);
    applyStimulus(1'b0, 1'b0, '0, '0, 4'b0, 1'b0, 2'd0, '0, 1'b1);
    cycleModel("drain2");
    idle();
    #1 check("count11 fetch_ready", fetch_ready, 1);
    applyStimulus(1'b0, 1'b0, '0, '0, 4'b0, 1'b0, 2'd0, '0, 1'b1);
    cycleModel("drain9");
    check("count9", count, 9);

    applyStimulus(1'b1, 1'b1, {4{32'h5A5A}}, 64'h4000, 4'b1111, 1'b0, 2'd0, '0, 1'b1);
    cycleModel("redirect");
    check("redirect count", count, 0);
    check("redirect out_valid", out_valid, 0);

    // Steady streaming across the pointer wrap: two in, two out per cycle.
    seq_inst = 32'h1000;
    for (int c = 0; c < 40; c++) begin
      applyStimulus(1'b0, 1'b1, {64'h0, seq_inst + 32'd1, seq_inst}, 64'h10000 + 64'(8*c),
                    4'b0011, 1'b0, 2'd0, '0, 1'b1);
      cycleModel($sformatf("stream%0d", c));
      seq_inst = seq_inst + 32'd2;
    end
    check("stream count stable", count, 2);

    for (int c = 0; c < 300; c++) begin
      rs = $urandom_range(0, 3);
      rl = $urandom_range(0, 4 - rs);
      rmask = 4'((1 << rl) - 1) << rs;
      applyStimulus(($urandom_range(0, 24) == 0), ($urandom_range(0, 9) < 7),
                    {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom},
                    rmask, 1'($urandom), 2'($urandom), $urandom, 1'($urandom));
      cycleModel($sformatf("rand%0d", c));
    end

    // Asynchronous reset in the middle of a cycle discards all contents.
    applyStimulus(1'b0, 1'b1, {32'h4, 32'h3, 32'h2, 32'h1}, 64'h7000, 4'b1111, 1'b0, 2'd0, '0, 1'b0);
    cycleModel("prereset");
    #2 reset_n = 1'b0;
    #1;
    check("async reset count", count, 0);
    check("async reset out_valid", out_valid, 0);
    model_q.delete();
    idle();
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("after reset");
    check("after reset fetch_ready", fetch_ready, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/inst_buffer_mw.md
INST_BUFFER_MW -- requirements
Module: inst_buffer_mw

Interface
REQ-001 Parameter DEPTH, default 16, number of 32-bit instruction entries; power of two, >=8.
REQ-002 Parameter DEQ_WIDTH, default 2, instructions presented per cycle; legal values 1..4.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 redirect_valid  input  1  flush request from backend or PC redirect.
REQ-006 fetch_valid  input  1  fetch block offered.
REQ-007 fetch_ready  output  1  buffer can accept a full fetch block.
REQ-008 fetch_insts  input  128  four instructions; lane i is bits [32i+31:32i].
REQ-009 fetch_pc  input  64  PC of lane 0.
REQ-010 fetch_mask  input  4  lane valid bits; contiguous run of ones.
REQ-011 fetch_predicttaken  input  1  one lane of the block is predicted taken.
REQ-012 fetch_predictlane  input  2  index of the predicted-taken lane.
REQ-013 fetch_predicttarget  input  32  predicted target for that lane.
REQ-014 out_valid  output  DEQ_WIDTH  per-slot valid, thermometer-coded from slot 0.
REQ-015 out_ready  input  1  consumer takes all valid slots this cycle.
REQ-016 out_inst  output  32*DEQ_WIDTH  instruction per slot.
REQ-017 out_pc  output  64*DEQ_WIDTH  PC per slot.
REQ-018 out_predicttaken  output  DEQ_WIDTH  prediction flag per slot.
REQ-019 out_predicttarget  output  32*DEQ_WIDTH  predicted target per slot.
REQ-020 count  output  clog2(DEPTH)+1  current occupancy.

Function
REQ-021 Storage: circular array of DEPTH entries {inst, pc, predicttaken, predicttarget}; head/tail pointers clog2(DEPTH)+1 bits, wrap mod 2*DEPTH; full = (count==DEPTH), empty = (count==0).
REQ-022 fetch_ready = (DEPTH - count >= 4) & ~redirect_valid, computed from registered count (pre-dequeue, conservative).
REQ-023 Enqueue when fetch_valid & fetch_ready: mask lanes compacted in lane order, written at tail, tail += popcount(fetch_mask); fetch_mask==0 writes nothing.
REQ-024 Lane i PC = fetch_pc + 4*i, 64-bit modulo arithmetic.
REQ-025 Lane i stores predicttaken=1 and predicttarget=fetch_predicttarget only if fetch_predicttaken & (fetch_predictlane==i) & fetch_mask[i]; else 0 and 0.
REQ-026 Enqueued entries visible on outputs the cycle after the write (1-cycle latency); no same-cycle bypass.
REQ-027 out_valid[k] = (count > k); slot k shows entry head+k (wrap); invalid slots drive all data fields to 0.
REQ-028 Dequeue when out_ready & out_valid[0]: head += popcount(out_valid); out_ready with out_valid==0 has no effect.
REQ-029 Simultaneous enqueue and dequeue: count_next = count + enq_n - deq_n; both pointers advance.
REQ-030 redirect_valid=1: next cycle head=tail=0, count=0; same-cycle fetch and dequeue discarded; out_valid next cycle all 0.
REQ-031 No overflow: enqueue never accepted with fewer than 4 free entries; fetch_valid with fetch_ready=0 changes no state.
REQ-032 Order preserved: instructions leave in exact enqueue order across pointer wrap.

Reset
REQ-033 reset_n=0 asynchronously clears head, tail, count to 0; out_valid=0, out_predicttaken=0, out data=0, fetch_ready=1 after release.
REQ-034 Reset mid-operation discards all contents; array data need not be cleared.

Verification
REQ-035 Reset, enqueue inst 0x11,0x22,0x33,0x44 pc=0x80000000 mask=1111 -> next cycle out_valid=11, slot0 0x11/0x80000000, slot1 0x22/0x80000004, count=4.
REQ-036 Mask 0110, predicttaken lane 2 target 0x80000100 -> two entries pc +4/+8; second has predicttaken=1, target 0x80000100; first 0.
REQ-037 Fill DEPTH=16 to count 13 -> fetch_ready=0; dequeue 2 (count 11) -> fetch_ready=1 following cycle.
REQ-038 Enqueue+dequeue every cycle for 40 cycles with wrap -> output sequence equals input sequence, count stable.
REQ-039 count=9, redirect_valid with fetch_valid and out_ready high -> next cycle count=0, out_valid=0, nothing enqueued.
REQ-040 count=1, DEQ_WIDTH=2 -> out_valid=01, slot1 data 0; out_ready pops one entry.
